pc_call_stack_unit: RTL and testbench
=====================================

PC_CALL_STACK_UNIT -- requirements
Module: pc_call_stack_unit

Interface
REQ-001 Parameter: ADDR_W, 32, program counter and target width in bits.
REQ-002 Parameter: DEPTH, 8, return-stack entries; power of two, at least 2.
REQ-003 Parameter: RESET_PC, 0, PC value after reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 write_pc  input  1  end-of-instruction strobe from control unit; all control inputs sampled only when high.
REQ-007 branch  input  2  00 sequential, 10 jump/branch, 01 halt, 11 reserved.
REQ-008 brfl_control  input  1  qualifies branch=10 as conditional on flag_in.
REQ-009 flag_in  input  1  ALU condition flag for conditional branch.
REQ-010 push  input  1  call: save return address, jump to target.
REQ-011 pop  input  1  ret: jump to popped return address.
REQ-012 target  input  ADDR_W  jump/branch/call destination.
REQ-013 pc  output  ADDR_W  registered current instruction address.
REQ-014 halted  output  1  high in HALT or FAULT state.
REQ-015 fault  output  2  sticky cause: 00 none, 01 overflow, 10 underflow, 11 push+pop conflict.
REQ-016 depth  output  log2(DEPTH)+1  registered count of valid stack entries.

Function
REQ-017 FSM states RUN, HALT, FAULT; reset enters RUN.
REQ-018 In RUN, without write_pc, pc, stack and depth SHALL hold.
REQ-019 In RUN with write_pc, next pc SHALL be chosen by priority: conflict > halt > pop > push > branch > sequential.
REQ-020 Conflict (push=1, pop=1): pc, stack, depth unchanged; fault<=11; state<=FAULT.
REQ-021 Halt (branch=01): pc unchanged; state<=HALT.
REQ-022 Pop with depth>0: pc<=top entry; depth decrements.
REQ-023 Pop with depth=0: pc unchanged; fault<=10; state<=FAULT.
REQ-024 Push with depth<DEPTH: stack[depth]<=pc+1; pc<=target; depth increments.
REQ-025 Push with depth=DEPTH: pc, stack unchanged; fault<=01; state<=FAULT.
REQ-026 branch=10 with brfl_control=0: pc<=target.
REQ-027 branch=10 with brfl_control=1: pc<=target if flag_in=1, else pc<=pc+1.
REQ-028 branch=00 or 11 (no push/pop): pc<=pc+1.
REQ-029 pc+1 and return address SHALL wrap modulo 2^ADDR_W (all-ones -> 0).
REQ-030 Update latency: new pc visible on the clock edge following the sampled write_pc cycle; exactly one update per write_pc cycle.
REQ-031 HALT and FAULT SHALL ignore all inputs except rst; pc, depth, fault frozen.
REQ-032 Stack storage contents not observable except via pop; stale entries above depth are don't-care.

Reset
REQ-033 rst high at a rising edge SHALL set pc=RESET_PC, depth=0, fault=00, halted=0, state=RUN, overriding write_pc that cycle.
REQ-034 Reset mid-call-sequence SHALL discard all stack entries; subsequent pop faults with underflow.
REQ-035 Outputs SHALL be defined (no X) from the first edge with rst high.

Verification
REQ-036 Reset, then 3 write_pc pulses with branch=00 -> pc 0,1,2,3; depth 0; halted 0.
REQ-037 pc=5, push with target=0x40 -> pc=0x40, depth=1; then pop -> pc=6, depth=0.
REQ-038 branch=10, brfl_control=1, target=0x20 from pc=7: flag_in=0 -> pc=8; flag_in=1 -> pc=0x20.
REQ-039 9 consecutive pushes (DEPTH=8) -> depth=8 after 8th; 9th: fault=01, halted=1, pc equals 8th target; further write_pc ignored.
REQ-040 Pop at depth=0 -> fault=10, halted=1; push+pop together -> fault=11; rst clears both to fault=00, pc=0.
REQ-041 pc=0xFFFFFFFF, branch=00 -> pc=0; push at pc=0xFFFFFFFF then pop -> pc=0.

Source files
------------

// File: rtl/pc_call_stack_unit_if.sv
// Bus between the control unit and the PC / call-stack unit.
// Handshake: write_pc is a one-cycle strobe with no back-pressure; all other inputs are only meaningful when it is high.
interface pc_call_stack_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 8
);
    localparam int DW = $clog2(DEPTH) + 1;

    logic              write_pc;
    logic [1:0]        branch;
    logic              brfl_control;
    logic              flag_in;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc;
    logic              halted;
    logic [1:0]        fault;
    logic [DW-1:0]     depth;

    modport master (
        output write_pc, branch, brfl_control, flag_in, push, pop, target,
        input  pc, halted, fault, depth
    );

    modport slave (
        input  write_pc, branch, brfl_control, flag_in, push, pop, target,
        output pc, halted, fault, depth
    );
endinterface

// File: rtl/pc_call_stack_unit.sv
// Program counter with call/return stack; RUN/HALT/FAULT control FSM.
// One pc update per write_pc strobe, visible after the next rising edge.
module pc_call_stack_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    pc_call_stack_unit_if.slave        bus,
    output logic [1:0]                 o_dbg_state
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int DW    = PTR_W + 1;
    localparam logic [DW-1:0] FULL_DEPTH = DW'(DEPTH);

    localparam logic [1:0] F_NONE      = 2'b00;
    localparam logic [1:0] F_OVERFLOW  = 2'b01;
    localparam logic [1:0] F_UNDERFLOW = 2'b10;
    localparam logic [1:0] F_CONFLICT  = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [DW-1:0]     r_depth;
    logic [1:0]        r_fault;
    logic [ADDR_W-1:0] r_stack [DEPTH];

    state_t            w_state_nxt;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [DW-1:0]     w_depth_nxt;
    logic [1:0]        w_fault_nxt;
    logic              w_push_we;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [PTR_W-1:0]  w_push_idx;
    logic [PTR_W-1:0]  w_top_idx;
    logic              w_empty;
    logic              w_full;

    // pc + 1 wraps naturally at ADDR_W bits; also serves as the return address.
    assign w_pc_inc   = r_pc + 1'b1;
    assign w_push_idx = r_depth[PTR_W-1:0];
    assign w_top_idx  = r_depth[PTR_W-1:0] - 1'b1;
    assign w_empty    = (r_depth == '0);
    assign w_full     = (r_depth == FULL_DEPTH);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_depth_nxt = r_depth;
        w_fault_nxt = r_fault;
        w_push_we   = 1'b0;

        if (r_state == ST_RUN && bus.write_pc) begin
            if (bus.push && bus.pop) begin
                w_fault_nxt = F_CONFLICT;
                w_state_nxt = ST_FAULT;
            end else if (bus.branch == 2'b01) begin
                w_state_nxt = ST_HALT;
            end else if (bus.pop) begin
                if (w_empty) begin
                    w_fault_nxt = F_UNDERFLOW;
                    w_state_nxt = ST_FAULT;
                end else begin
                    w_pc_nxt    = r_stack[w_top_idx];
                    w_depth_nxt = r_depth - 1'b1;
                end
            end else if (bus.push) begin
                if (w_full) begin
                    w_fault_nxt = F_OVERFLOW;
                    w_state_nxt = ST_FAULT;
                end else begin
                    w_push_we   = 1'b1;
                    w_pc_nxt    = bus.target;
                    w_depth_nxt = r_depth + 1'b1;
                end
            end else if (bus.branch == 2'b10) begin
                if (bus.brfl_control && !bus.flag_in) begin
                    w_pc_nxt = w_pc_inc;
                end else begin
                    w_pc_nxt = bus.target;
                end
            end else begin
                w_pc_nxt = w_pc_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
            r_depth <= '0;
            r_fault <= F_NONE;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_depth <= w_depth_nxt;
            r_fault <= w_fault_nxt;
        end
    end

    // Storage needs no reset: entries at or above depth are never read.
    always_ff @(posedge clk) begin
        if (w_push_we && !rst) begin
            r_stack[w_push_idx] <= w_pc_inc;
        end
    end

    assign bus.pc      = r_pc;
    assign bus.depth   = r_depth;
    assign bus.fault   = r_fault;
    assign bus.halted  = (r_state != ST_RUN);
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_pc_call_stack_unit.sv
// Directed bench for pc_call_stack_unit: vector table plus hand sequences
// for stack overflow, LIFO order, reset mid-call and address wrap.
module tb_pc_call_stack_unit;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 8;
    localparam int DW     = $clog2(DEPTH) + 1;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;

    pc_call_stack_unit_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

    pc_call_stack_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC('0)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .o_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        wp;
        logic [1:0]  br;
        logic        brfl;
        logic        flag;
        logic        push;
        logic        pop;
        logic [31:0] target;
        logic [31:0] exp_pc;
        logic [DW-1:0] exp_depth;
        logic        exp_halted;
        logic [1:0]  exp_fault;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];
    int   n_checks;
    int   n_errors;

    function automatic vec_t mk(logic r, logic wp, logic [1:0] br, logic brfl, logic flag,
                                logic push, logic pop, logic [31:0] tgt, logic [31:0] epc,
                                int edep, logic eh, logic [1:0] ef);
        vec_t v;
        v.rst = r; v.wp = wp; v.br = br; v.brfl = brfl; v.flag = flag;
        v.push = push; v.pop = pop; v.target = tgt;
        v.exp_pc = epc; v.exp_depth = DW'(edep); v.exp_halted = eh; v.exp_fault = ef;
        return v;
    endfunction

    task automatic drive(input logic r, input logic wp, input logic [1:0] br, input logic brfl,
                         input logic flag, input logic push, input logic pop, input logic [31:0] tgt);
        rst = r;
        bus.write_pc = wp; bus.branch = br; bus.brfl_control = brfl;
        bus.flag_in = flag; bus.push = push; bus.pop = pop; bus.target = tgt;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.write_pc = 1'b0; bus.push = 1'b0; bus.pop = 1'b0;
        bus.branch = 2'b00; bus.brfl_control = 1'b0; bus.flag_in = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] epc, input int edep,
                           input logic eh, input logic [1:0] ef);
        chk({tag, ".pc"},     bus.pc, epc);
        chk({tag, ".depth"},  32'(bus.depth), 32'(edep));
        chk({tag, ".halted"}, 32'(bus.halted), 32'(eh));
        chk({tag, ".fault"},  32'(bus.fault), 32'(ef));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.write_pc = 1'b0; bus.branch = 2'b00; bus.brfl_control = 1'b0;
        bus.flag_in = 1'b0; bus.push = 1'b0; bus.pop = 1'b0; bus.target = '0;

        //            rst wp  br     bf  fl  pu  po  target      exp_pc     dep h  fault
        vecs[0]  = mk(1, 0, 2'b00, 0, 0, 0, 0, 32'h0,      32'h0,      0, 0, 2'b00);
        vecs[1]  = mk(0, 1, 2'b00, 0, 0, 0, 0, 32'h0,      32'h1,      0, 0, 2'b00);
        vecs[2]  = mk(0, 1, 2'b00, 0, 0, 0, 0, 32'h0,      32'h2,      0, 0, 2'b00);
        vecs[3]  = mk(0, 1, 2'b00, 0, 0, 0, 0, 32'h0,      32'h3,      0, 0, 2'b00);
        vecs[4]  = mk(0, 0, 2'b10, 0, 0, 1, 0, 32'h99,     32'h3,      0, 0, 2'b00);
        vecs[5]  = mk(0, 1, 2'b00, 0, 0, 0, 0, 32'h0,      32'h4,      0, 0, 2'b00);
        vecs[6]  = mk(0, 1, 2'b00, 0, 0, 0, 0, 32'h0,      32'h5,      0, 0, 2'b00);
        vecs[7]  = mk(0, 1, 2'b00, 0, 0, 1, 0, 32'h40,     32'h40,     1, 0, 2'b00);
        vecs[8]  = mk(0, 1, 2'b00, 0, 0, 0, 1, 32'h0,      32'h6,      0, 0, 2'b00);
        vecs[9]  = mk(0, 1, 2'b00, 0, 0, 0, 0, 32'h0,      32'h7,      0, 0, 2'b00);
        vecs[10] = mk(0, 1, 2'b10, 1, 0, 0, 0, 32'h20,     32'h8,      0, 0, 2'b00);
        vecs[11] = mk(0, 1, 2'b10, 0, 0, 0, 0, 32'h7,      32'h7,      0, 0, 2'b00);
        vecs[12] = mk(0, 1, 2'b10, 1, 1, 0, 0, 32'h20,     32'h20,     0, 0, 2'b00);
        vecs[13] = mk(0, 1, 2'b11, 0, 0, 0, 0, 32'h55,     32'h21,     0, 0, 2'b00);
        vecs[14] = mk(0, 1, 2'b00, 0, 0, 0, 1, 32'h0,      32'h21,     0, 1, 2'b10);
        vecs[15] = mk(0, 1, 2'b10, 0, 0, 0, 0, 32'h77,     32'h21,     0, 1, 2'b10);
        vecs[16] = mk(1, 0, 2'b00, 0, 0, 0, 0, 32'h0,      32'h0,      0, 0, 2'b00);
        vecs[17] = mk(0, 1, 2'b00, 0, 0, 1, 1, 32'h50,     32'h0,      0, 1, 2'b11);
        vecs[18] = mk(1, 0, 2'b00, 0, 0, 0, 0, 32'h0,      32'h0,      0, 0, 2'b00);
        vecs[19] = mk(0, 1, 2'b00, 0, 0, 0, 0, 32'h0,      32'h1,      0, 0, 2'b00);
        vecs[20] = mk(0, 1, 2'b01, 0, 0, 1, 0, 32'h60,     32'h1,      0, 1, 2'b00);
        vecs[21] = mk(0, 1, 2'b00, 0, 0, 0, 0, 32'h0,      32'h1,      0, 1, 2'b00);
        vecs[22] = mk(1, 1, 2'b10, 0, 0, 0, 0, 32'h88,     32'h0,      0, 0, 2'b00);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].rst, vecs[i].wp, vecs[i].br, vecs[i].brfl, vecs[i].flag,
                  vecs[i].push, vecs[i].pop, vecs[i].target);
            chk_all($sformatf("vec%0d", i), vecs[i].exp_pc, int'(vecs[i].exp_depth),
                    vecs[i].exp_halted, vecs[i].exp_fault);
        end

        // Fill the stack, then overflow on the ninth push.
        drive(1, 0, 2'b00, 0, 0, 0, 0, 32'h0);
        for (int k = 1; k <= DEPTH; k++) begin
            drive(0, 1, 2'b00, 0, 0, 1, 0, 32'h100 + 32'(k) * 32'h10);
            chk_all($sformatf("push%0d", k), 32'h100 + 32'(k) * 32'h10, k, 0, 2'b00);
        end
        drive(0, 1, 2'b00, 0, 0, 1, 0, 32'h900);
        chk_all("overflow", 32'h180, DEPTH, 1, 2'b01);
        chk("overflow.state", 32'(dbg_state), 32'd2);
        drive(0, 1, 2'b00, 0, 0, 0, 1, 32'h0);
        chk_all("overflow_frozen", 32'h180, DEPTH, 1, 2'b01);

        // Nested call/return order.
        drive(1, 0, 2'b00, 0, 0, 0, 0, 32'h0);
        drive(0, 1, 2'b00, 0, 0, 1, 0, 32'h10);
        drive(0, 1, 2'b00, 0, 0, 1, 0, 32'h20);
        chk_all("nest_push2", 32'h20, 2, 0, 2'b00);
        drive(0, 1, 2'b00, 0, 0, 0, 1, 32'h0);
        chk_all("nest_pop1", 32'h11, 1, 0, 2'b00);
        drive(0, 1, 2'b00, 0, 0, 0, 1, 32'h0);
        chk_all("nest_pop2", 32'h1, 0, 0, 2'b00);

        // Reset in the middle of a call sequence discards the stack.
        drive(0, 1, 2'b00, 0, 0, 1, 0, 32'h30);
        drive(0, 1, 2'b00, 0, 0, 1, 0, 32'h40);
        drive(1, 0, 2'b00, 0, 0, 0, 0, 32'h0);
        chk_all("mid_reset", 32'h0, 0, 0, 2'b00);
        drive(0, 1, 2'b00, 0, 0, 0, 1, 32'h0);
        chk_all("mid_reset_pop", 32'h0, 0, 1, 2'b10);

        // Address wrap on sequential step and on return address.
        drive(1, 0, 2'b00, 0, 0, 0, 0, 32'h0);
        drive(0, 1, 2'b10, 0, 0, 0, 0, 32'hFFFF_FFFF);
        chk("wrap_jump.pc", bus.pc, 32'hFFFF_FFFF);
        drive(0, 1, 2'b00, 0, 0, 0, 0, 32'h0);
        chk_all("wrap_seq", 32'h0, 0, 0, 2'b00);
        drive(0, 1, 2'b10, 0, 0, 0, 0, 32'hFFFF_FFFF);
        drive(0, 1, 2'b00, 0, 0, 1, 0, 32'h30);
        chk_all("wrap_push", 32'h30, 1, 0, 2'b00);
        drive(0, 1, 2'b00, 0, 0, 0, 1, 32'h0);
        chk_all("wrap_pop", 32'h0, 0, 0, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
